dmem_stage: RTL and testbench

- Data-memory stage of the RISC-V core, directly downstream of the ALU.
- Takes the ALU result as a byte address, plus store data and funct3 from decode. Performs LB/LH/LW/LBU/LHU/SB/SH/SW against an internal word-organised RAM.
- Returns sign- or zero-extended load data to write-back.
- Has a programmable wait-state FSM and a stall output, so the core can model slow memory.

---
 rtl/dmem_stage.sv | 198 +++++++++++++++++++
 tb/tb_dmem_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_stage.sv
// dmem_stage: RISC-V data-memory stage with a word-organised RAM and a
// programmable wait-state FSM.
// Handles LB/LH/LW/LBU/LHU/SB/SH/SW. Misaligned accesses and illegal funct3
// values return err with no write.
// Optional feature macro: DMEM_BOUNDS_CHECK_EN. When it is defined, addresses
// at or beyond DEPTH*4 also raise err. When it is undefined, addresses wrap
// modulo DEPTH*4.
module dmem_stage #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        req_ready,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  count;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] mem [DEPTH];

    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic [31:0]   word;
    logic          commit;
    logic          misaligned;
    logic          out_of_range;
    logic          access_err;
    logic [7:0]    sel_byte;
    logic [15:0]   sel_half;
    logic [31:0]   load_data;
    logic [31:0]   store_data;
    logic [3:0]    byte_en;

    assign word_idx   = addr_q[AW+1:2];
    assign lane       = addr_q[1:0];
    assign word       = mem[word_idx];
    assign commit     = (state == ACCESS) && (count == 4'd0);
    assign access_err = misaligned | out_of_range;

    // State register; reset returns to IDLE and aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic and handshake outputs decoded from the current state.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        stall      = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = ACCESS;
            end
            ACCESS: begin
                stall = 1'b1;
                if (count == 4'd0) state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Wait counter: loaded on accept, counts down to the commit cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 4'd0;
        end else if (state == IDLE && req_valid) begin
            count <= 4'(WAIT_CYCLES);
        end else if (state == ACCESS && count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    // Capture the request so the requester is free once it has been accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else if (state == IDLE && req_valid) begin
            we_q    <= req_we;
            f3_q    <= funct3;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // Alignment and funct3 legality; illegal encodings count as misaligned.
    always_comb begin
        misaligned = 1'b0;
        case (f3_q)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = lane[0];
            3'b010:         misaligned = (lane != 2'b00);
            default:        misaligned = 1'b1;
        endcase
    end

`ifdef DMEM_BOUNDS_CHECK_EN
    localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;
    // Anything at or past the end of the RAM is an error rather than a wrap.
    always_comb begin
        out_of_range = ({1'b0, addr_q} >= LIMIT);
    end
`else
    // Upper address bits are ignored, so the address wraps around the RAM.
    always_comb begin
        out_of_range = 1'b0;
    end
`endif

    // Pick the addressed byte/halfword and extend it to 32 bits.
    always_comb begin
        sel_byte  = word[7:0];
        sel_half  = lane[1] ? word[31:16] : word[15:0];
        load_data = 32'd0;
        case (lane)
            2'd0: sel_byte = word[7:0];
            2'd1: sel_byte = word[15:8];
            2'd2: sel_byte = word[23:16];
            2'd3: sel_byte = word[31:24];
            default: sel_byte = word[7:0];
        endcase
        case (f3_q)
            3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  load_data = {24'd0, sel_byte};
            3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
            3'b101:  load_data = {16'd0, sel_half};
            3'b010:  load_data = word;
            default: load_data = 32'd0;
        endcase
    end

    // Replicate store data across lanes and build the byte enables.
    always_comb begin
        byte_en    = 4'b0000;
        store_data = wdata_q;
        case (f3_q)
            3'b000: begin
                byte_en    = 4'b0001 << lane;
                store_data = {4{wdata_q[7:0]}};
            end
            3'b001: begin
                byte_en    = lane[1] ? 4'b1100 : 4'b0011;
                store_data = {2{wdata_q[15:0]}};
            end
            3'b010: byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    // Byte-enabled RAM write in the commit cycle; faulty stores never write.
    always_ff @(posedge clk) begin
        if (commit && we_q && !access_err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[word_idx][8*i +: 8] <= store_data[8*i +: 8];
            end
        end
    end

    // Response registers: updated at commit and held until the next commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= 32'd0;
            err   <= 1'b0;
        end else if (commit) begin
            err   <= access_err;
            rdata <= (we_q || access_err) ? 32'd0 : load_data;
        end
    end

endmodule

// File: tb/tb_dmem_stage.sv
// tb_dmem_stage: directed scoreboard bench for dmem_stage.
// Stimulus pushes the expected {err, rdata} into a queue, and a monitor pops
// and compares it whenever resp_valid is seen.
module tb_dmem_stage;

    localparam int W = 1;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;
    localparam logic [2:0] F_BAD = 3'b011;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        req_ready;
    logic        stall;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        err;

    int          tests = 0;
    int          fails = 0;
    logic [32:0] exp_q [$];
    logic [32:0] mon_exp;

    dmem_stage #(.DEPTH(256), .WAIT_CYCLES(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .req_ready  (req_ready),
        .stall      (stall),
        .resp_valid (resp_valid),
        .rdata      (rdata),
        .err        (err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_resp: got a response, expected none");
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("resp_rdata", rdata, mon_exp[31:0]);
                checkOutput("resp_err", {31'd0, err}, {31'd0, mon_exp[32]});
            end
        end
    end

    // Issue one request, then check its latency and stall length.
    task automatic applyStimulus(input string name, input logic we, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input logic [31:0] exp_data, input logic exp_err);
        int n;
        int stalls;
        exp_q.push_back({exp_err, exp_data});
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        funct3    = f3;
        addr      = a;
        wdata     = d;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s_accept: got no req_ready, expected it within 50 cycles", name);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 1;
        stalls = 0;
        while (resp_valid !== 1'b1 && n < 50) begin
            if (stall === 1'b1) stalls++;
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({name, "_latency"}, 32'(n), 32'(W + 2));
        checkOutput({name, "_stall"}, 32'(stalls), 32'(W + 1));
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        funct3    = 3'b000;
        addr      = 32'd0;
        wdata     = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("reset_stall", {31'd0, stall}, 32'd0);
        checkOutput("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("reset_rdata", rdata, 32'd0);
        checkOutput("reset_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus("sw_10", 1'b1, F_W, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
        applyStimulus("lw_10", 1'b0, F_W, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("rdata_hold", rdata, 32'hDEADBEEF);

        applyStimulus("sw_20", 1'b1, F_W, 32'h20, 32'h0, 32'd0, 1'b0);
        applyStimulus("sb_21", 1'b1, F_B, 32'h21, 32'hFFFF_FF80, 32'd0, 1'b0);
        applyStimulus("lb_21", 1'b0, F_B, 32'h21, 32'd0, 32'hFFFFFF80, 1'b0);
        applyStimulus("lbu_21", 1'b0, F_BU, 32'h21, 32'd0, 32'h00000080, 1'b0);
        applyStimulus("sh_22", 1'b1, F_H, 32'h22, 32'hABCD_8001, 32'd0, 1'b0);
        applyStimulus("lh_22", 1'b0, F_H, 32'h22, 32'd0, 32'hFFFF8001, 1'b0);
        applyStimulus("lhu_22", 1'b0, F_HU, 32'h22, 32'd0, 32'h00008001, 1'b0);
        applyStimulus("lw_20", 1'b0, F_W, 32'h20, 32'd0, 32'h80018000, 1'b0);

        applyStimulus("sw_40", 1'b1, F_W, 32'h40, 32'h12345678, 32'd0, 1'b0);
        applyStimulus("lb_43", 1'b0, F_B, 32'h43, 32'd0, 32'h00000012, 1'b0);
        applyStimulus("lbu_42", 1'b0, F_BU, 32'h42, 32'd0, 32'h00000034, 1'b0);
        applyStimulus("lh_40", 1'b0, F_H, 32'h40, 32'd0, 32'h00005678, 1'b0);

        applyStimulus("lw_13_misal", 1'b0, F_W, 32'h13, 32'd0, 32'd0, 1'b1);
        applyStimulus("sh_11_misal", 1'b1, F_H, 32'h11, 32'h00001234, 32'd0, 1'b1);
        applyStimulus("lw_10_after", 1'b0, F_W, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
        applyStimulus("bad_funct3", 1'b0, F_BAD, 32'h10, 32'd0, 32'd0, 1'b1);
        applyStimulus("lw_10_ok", 1'b0, F_W, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

        // Held req_valid: two back-to-back loads, spaced by a full round trip.
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        funct3    = F_W;
        addr      = 32'h10;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready !== 1'b1 && n < 50);
        checkOutput("b2b_gap", 32'(n), 32'(W + 3));
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (resp_valid !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(negedge clk);

        // Reset while an SW is in ACCESS must abort it without writing.
        applyStimulus("sw_30", 1'b1, F_W, 32'h30, 32'h11111111, 32'd0, 1'b0);
        applyStimulus("lw_10_pre", 1'b0, F_W, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        funct3    = F_W;
        addr      = 32'h30;
        wdata     = 32'hCAFEF00D;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("abort_stall", {31'd0, stall}, 32'd0);
        checkOutput("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("abort_rdata", rdata, 32'd0);
        checkOutput("abort_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus("lw_30_after", 1'b0, F_W, 32'h30, 32'd0, 32'h11111111, 1'b0);

        applyStimulus("sw_00", 1'b1, F_W, 32'h0, 32'hA5A5A5A5, 32'd0, 1'b0);
`ifdef DMEM_BOUNDS_CHECK_EN
        applyStimulus("lw_400", 1'b0, F_W, 32'h400, 32'd0, 32'd0, 1'b1);
`else
        applyStimulus("lw_400", 1'b0, F_W, 32'h400, 32'd0, 32'hA5A5A5A5, 1'b0);
`endif

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("pending_resps", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
